// File: rtl/freq_meter_if.sv
// Measurement-side signals of freq_meter: the signal under test in, the BCD result out.
interface freq_meter_if;
  logic        sig_in;
  logic [11:0] bcd_out;
  logic        valid;
  logic        ovf;

  modport master (input sig_in, output bcd_out, valid, ovf);
  modport slave  (output sig_in, input bcd_out, valid, ovf);
endinterface

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of an asynchronous input over a
// GATE_LEN-cycle window into a saturating 3-digit BCD counter.
module freq_meter #(
  parameter int GATE_LEN    = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic          in_clk,
  input  logic          reset,
  freq_meter_if.master  fm
);
  localparam logic [11:0] GATE_LAST = 12'(GATE_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [11:0]            gate_q, gate_d;
  logic [2:0][3:0]        cnt_q, cnt_inc, cnt_d;
  logic                   sticky_q;
  logic [11:0]            bcd_q;
  logic                   ovf_q, valid_q;
  logic                   edge_det, close, at_max, carry;

  assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign close    = (gate_q == GATE_LAST);
  assign at_max   = (cnt_q == 12'h999);
  assign gate_d   = close ? 12'd0 : gate_q + 12'd1;

  // Ripple-carry decimal increment; at 999 the count holds instead of wrapping.
  always_comb begin
    cnt_inc = cnt_q;
    carry   = 1'b1;
    for (int d = 0; d < 3; d++) begin
      if (carry) begin
        if (cnt_q[d] == 4'd9) begin
          cnt_inc[d] = 4'd0;
        end else begin
          cnt_inc[d] = cnt_q[d] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
    cnt_d = at_max ? cnt_q : cnt_inc;
  end

  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      hist_q   <= 1'b0;
      gate_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], fm.sig_in};
      hist_q  <= sync_q[SYNC_STAGES-1];
      gate_q  <= gate_d;
      valid_q <= close;
      if (close) begin
        // An edge landing in the closing cycle belongs to the closing window.
        bcd_q    <= edge_det ? cnt_d : cnt_q;
        ovf_q    <= sticky_q | (edge_det & at_max);
        cnt_q    <= '0;
        sticky_q <= 1'b0;
      end else if (edge_det) begin
        cnt_q    <= cnt_d;
        sticky_q <= sticky_q | at_max;
      end
    end
  end

  assign fm.bcd_out = bcd_q;
  assign fm.ovf     = ovf_q;
  assign fm.valid   = valid_q;
endmodule

// File: tb/tb_freq_meter.sv
// Scoreboarded bench for freq_meter: two instances (short sync / long gate),
// expected window results derived from the driven sample stream.
module tb_freq_meter;
  localparam int G0 = 1000, S0 = 2, G1 = 4095, S1 = 3;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          rc;
  } exp_t;

  logic clk = 1'b0;
  logic rst0 = 1'b0, rst1 = 1'b0;
  always #5 clk = ~clk;

  freq_meter_if if0();
  freq_meter_if if1();

  freq_meter #(.GATE_LEN(G0), .SYNC_STAGES(S0)) u0 (.in_clk(clk), .reset(rst0), .fm(if0));
  freq_meter #(.GATE_LEN(G1), .SYNC_STAGES(S1)) u1 (.in_clk(clk), .reset(rst1), .fm(if1));

  exp_t        q0[$], q1[$];
  int          total = 0, bad = 0;
  int          rc[2];
  int          jx[2], acc[2];
  logic        prv[2];
  logic [11:0] last_b[2];
  logic        last_o[2];

  // Clock edges since reset release, per instance.
  always @(posedge clk) begin
    if (rst0) rc[0] <= 0; else rc[0] <= rc[0] + 1;
    if (rst1) rc[1] <= 0; else rc[1] <= rc[1] + 1;
  end

  function automatic int gl(input int u); return (u == 0) ? G0 : G1; endfunction
  function automatic int sl(input int u); return (u == 0) ? S0 : S1; endfunction

  function automatic logic [11:0] bcd_of(input int n);
    int m;
    m = (n > 999) ? 999 : n;
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic nib_ok(input logic [11:0] c);
    return (c[3:0] <= 4'd9) && (c[7:4] <= 4'd9) && (c[11:8] <= 4'd9);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Drive one sample (seen at the next rising edge) and update the window model.
  // A rising edge in sample j is counted in cycle j+S-1; cycle k closes a window
  // when k%G == G-1 and the result appears after rising edge k+1.
  task automatic drive(input int u, input logic v);
    int g, s, k;
    exp_t e;
    g = gl(u);
    s = sl(u);
    if (u == 0) if0.sig_in = v; else if1.sig_in = v;
    jx[u]++;
    k = jx[u] + s - 1;
    if (v && !prv[u]) acc[u]++;
    prv[u] = v;
    if (k % g == g - 1) begin
      e.bcd = bcd_of(acc[u]);
      e.ovf = (acc[u] > 999);
      e.rc  = k + 1;
      if (u == 0) q0.push_back(e); else q1.push_back(e);
      acc[u] = 0;
    end
    @(negedge clk);
  endtask

  // mode 0 constant a!=0, 1 toggle every a samples, 2 a pulses after offset 100,
  // 3 single-sample pulse at sample phase a, 4 random high with a% probability.
  task automatic run(input int u, input int mode, input int n, input int a);
    for (int i = 0; i < n; i++) begin
      logic v;
      int   jn;
      jn = jx[u] + 1;
      case (mode)
        0:       v = (a != 0);
        1:       v = ((jn / a) % 2) == 1;
        2:       v = (i >= 100) && (i < 100 + 4 * a) && (((i - 100) % 4) < 2);
        3:       v = ((jn % gl(u)) == a);
        default: v = ($urandom_range(0, 99) < a);
      endcase
      drive(u, v);
    end
  endtask

  task automatic mon(input int u);
    logic        r, vld, o;
    logic [11:0] b, c;
    exp_t        e;
    int          sz;
    if (u == 0) begin
      r = rst0; vld = if0.valid; b = if0.bcd_out; o = if0.ovf; c = u0.cnt_q; sz = q0.size();
    end else begin
      r = rst1; vld = if1.valid; b = if1.bcd_out; o = if1.ovf; c = u1.cnt_q; sz = q1.size();
    end
    if (r) begin
      last_b[u] = '0;
      last_o[u] = 1'b0;
      return;
    end
    chk($sformatf("nibble_range_u%0d", u), {31'd0, nib_ok(c)}, 32'd1);
    if (vld) begin
      total++;
      if (sz == 0) begin
        bad++;
        $display("FAIL unexpected_valid_u%0d: got valid bcd=%h at cycle %0d want no valid", u, b, rc[u]);
      end else begin
        if (u == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk($sformatf("bcd_u%0d", u), {20'd0, b}, {20'd0, e.bcd});
        chk($sformatf("ovf_u%0d", u), {31'd0, o}, {31'd0, e.ovf});
        chk($sformatf("valid_cycle_u%0d", u), rc[u], e.rc);
        last_b[u] = e.bcd;
        last_o[u] = e.ovf;
      end
    end else begin
      chk($sformatf("hold_u%0d", u), {19'd0, o, b}, {19'd0, last_o[u], last_b[u]});
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic chk_zero(input int u, input string nm);
    if (u == 0) chk(nm, {19'd0, if0.valid, if0.ovf, if0.bcd_out}, 32'd0);
    else        chk(nm, {19'd0, if1.valid, if1.ovf, if1.bcd_out}, 32'd0);
  endtask

  // Mid-window reset with the input held at sig_hold through release.
  task automatic reset0(input int cycles, input logic sig_hold);
    rst0 = 1'b1;
    if0.sig_in = sig_hold;
    #1;
    chk_zero(0, "reset_immediate_u0");
    repeat (cycles) @(negedge clk);
    rst0 = 1'b0;
    jx[0] = 0; acc[0] = 0; prv[0] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    if0.sig_in = 1'b0;
    if1.sig_in = 1'b0;
    for (int u = 0; u < 2; u++) begin
      jx[u] = 0; acc[u] = 0; prv[u] = 1'b0; last_b[u] = '0; last_o[u] = 1'b0;
    end
    #2;
    rst0 = 1'b1;
    rst1 = 1'b1;
    #1;
    chk_zero(0, "reset_state_u0");
    chk_zero(1, "reset_state_u1");
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    fork
      begin
        run(0, 0, G0, 0);
        run(0, 1, 2 * G0, 4);
        run(0, 2, G0, 9);
        run(0, 2, G0, 10);
        run(0, 2, G0, 99);
        run(0, 2, G0, 100);
        run(0, 3, G0, G0 - 2);
        run(0, 3, G0, G0 - 1);
        run(0, 3, G0, G0 - 2);
        run(0, 3, G0, G0 - 1);
        run(0, 4, G0, 5);
        run(0, 4, G0, 50);
        run(0, 4, G0, 30);
        run(0, 2, 500, 40);
        reset0(3, 1'b1);
        run(0, 0, 20, 1);
        run(0, 0, G0, 0);
        run(0, 4, G0, 20);
        run(0, 0, G0, 0);
      end
      begin
        // Toggle stops S-1 samples early so the following window sees no edge.
        run(1, 1, G1 - S1 + 1, 1);
        run(1, 0, G1 + 10, 0);
        repeat (10) @(negedge clk);
        rst1 = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_LEN, default 1000, gate window length in in_clk cycles; legal range 2..4095.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for sig_in; legal range 2..3.
REQ-003 in_clk  input  1  sole clock, rising-edge; nominal 1 kHz reference.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sig_in  input  1  signal under measurement, asynchronous to in_clk.
REQ-006 bcd_out  output  12  last completed measurement, 3 BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-007 valid  output  1  one-cycle pulse, bcd_out/ovf updated this cycle.
REQ-008 ovf  output  1  last completed window saw more than 999 rising edges.

Function
REQ-009 sig_in SHALL pass through SYNC_STAGES flops, then one further history flop; an edge is detected when synchronized value is 1 and history value is 0.
REQ-010 A detected edge SHALL be counted by a 3-digit BCD counter; units roll 9->0 and carry to tens, tens 9->0 carry to hundreds.
REQ-011 Every digit of the edge counter SHALL hold 0..9 at all times; no nibble may ever hold A..F.
REQ-012 Edge counter at 999 with a further edge SHALL hold 999 and set an internal sticky overflow flag; it SHALL NOT wrap to 000.
REQ-013 Gate counter SHALL be binary, 12 bits, counting 0..GATE_LEN-1 then wrapping to 0, one increment per in_clk.
REQ-014 Window close SHALL be the cycle in which the gate counter equals GATE_LEN-1.
REQ-015 On window close, bcd_out SHALL load the edge count including any edge detected in that same cycle, saturated per REQ-012.
REQ-016 On window close, ovf SHALL load the sticky flag, including overflow caused by an edge in that same cycle.
REQ-017 bcd_out, ovf and valid SHALL be registered and change together on the clock edge that ends the close cycle; valid SHALL be high for exactly one cycle per window.
REQ-018 On window close, edge counter SHALL reset to 000 and sticky flag to 0; the next window begins counting the following cycle with no lost or double-counted edge.
REQ-019 bcd_out and ovf SHALL hold their value between valid pulses.
REQ-020 Measurement latency: sig_in transition to edge detect = SYNC_STAGES+1 cycles; edges within that latency of a window boundary fall into the window in which they are detected.
REQ-021 sig_in pulses shorter than one in_clk period MAY be missed; at most one edge per two in_clk cycles is countable.

Reset
REQ-022 While reset is high: bcd_out=12'h000, ovf=0, valid=0, gate counter=0, edge counter=000, sticky flag=0, all synchronizer and history flops=0.
REQ-023 Reset SHALL take effect immediately without a clock edge; first window SHALL start on the first in_clk rising edge after reset deasserts.
REQ-024 Reset mid-window SHALL discard the partial count; no valid pulse SHALL be produced for the aborted window.
REQ-025 An input held high through reset release SHALL register one edge (history=0 after reset).

Verification
REQ-026 GATE_LEN=1000, sig_in toggling every 4 in_clk (125 rising edges/window) -> each valid shows bcd_out=12'h125, ovf=0, valid pulses exactly 1000 cycles apart.
REQ-027 GATE_LEN=1000, sig_in held 0 -> bcd_out=12'h000, ovf=0 each window; first valid on cycle 1000 after reset release.
REQ-028 GATE_LEN=4095, sig_in toggling every cycle (~2047 edges) -> bcd_out=12'h999, ovf=1; next window with sig_in=0 -> bcd_out=12'h000, ovf=0.
REQ-029 Exactly 9, 10, 99, 100 edges per window -> bcd_out 12'h009, 12'h010, 12'h099, 12'h100; no nibble ever exceeds 9 (assertion on internal counter).
REQ-030 Single edge detected in gate cycle GATE_LEN-1 -> counted in closing window; single edge detected in cycle 0 -> counted in next window; totals conserved across 10 windows.
REQ-031 Reset asserted for 3 cycles at gate cycle 500 with 40 edges accumulated -> outputs 0 immediately, no valid for aborted window, next valid 1000 cycles after release.
